// File: rtl/lsu_mem_master.sv
// RV32I load/store unit driving a word-wide strobe memory interface.
// Sub-word stores are done as read-modify-write of the containing word.
module lsu_mem_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_err,
    output logic [1:0]  o_err_cause,
    output logic        o_stb,
    output logic        o_wr_en,
    output logic [31:0] o_addr,
    output logic [31:0] o_write_data,
    input  logic        i_rd_ack,
    input  logic [31:0] i_read_data
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_is_store;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_load_data;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_err_cause;

    logic          w_illegal;
    logic          w_misaligned;
    logic          w_timeout;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_extract;
    logic [31:0]   w_merge;

    // Request checks work on the raw inputs so errors resolve in the accept cycle.
    always_comb begin
        // NOTE: defaults first, so no path through the block leaves a signal unassigned (no latch).
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (i_is_store) begin
            w_illegal = (i_funct3 > 3'd2);
        end else begin
            w_illegal = (i_funct3 == 3'd3) || (i_funct3 >= 3'd6);
        end
        case (i_funct3[1:0])
            2'b01:   w_misaligned = i_addr[0];
            2'b10:   w_misaligned = (i_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_timeout = (TIMEOUT > 0) && (r_state == S_RD) && !i_rd_ack
                       && (r_cnt == CW'(TIMEOUT - 1));

    assign w_byte = i_read_data[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = i_read_data[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_extract = i_read_data;
        w_merge   = i_read_data;
        case (r_funct3)
            3'd0:    w_extract = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_extract = {{16{w_half[15]}}, w_half};
            3'd4:    w_extract = {24'd0, w_byte};
            3'd5:    w_extract = {16'd0, w_half};
            default: w_extract = i_read_data;
        endcase
        // r_wdata still holds the raw store data while in RD.
        if (r_funct3[1:0] == 2'b00) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req && !w_illegal && !w_misaligned) begin
                    w_next_state = (i_is_store && i_funct3 == 3'd2) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (i_rd_ack) begin
                    w_next_state = r_is_store ? S_WR : S_IDLE;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WR:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_load_data <= 32'd0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cause <= 2'b00;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cause <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_is_store <= i_is_store;
                        r_funct3   <= i_funct3;
                        r_addr     <= i_addr;
                        r_wdata    <= i_store_data;
                        r_cnt      <= '0;
                        if (w_illegal) begin
                            r_done      <= 1'b1;
                            r_err       <= 1'b1;
                            r_err_cause <= 2'b10;
                        end else if (w_misaligned) begin
                            r_done      <= 1'b1;
                            r_err       <= 1'b1;
                            r_err_cause <= 2'b01;
                        end
                    end
                end
                S_RD: begin
                    if (i_rd_ack) begin
                        if (r_is_store) begin
                            r_wdata <= w_merge;
                        end else begin
                            r_done      <= 1'b1;
                            r_load_data <= w_extract;
                        end
                    end else if (w_timeout) begin
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                        r_err_cause <= 2'b11;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR:    r_done <= 1'b1;
                default: r_done <= 1'b0;
            endcase
        end
    end

    // Bus outputs decode straight from state, so a reset drops o_wr_en at once.
    assign o_ready      = (r_state == S_IDLE);
    assign o_stb        = (r_state == S_RD) || (r_state == S_WR);
    assign o_wr_en      = (r_state == S_WR);
    assign o_addr       = o_stb ? {r_addr[31:2], 2'b00} : 32'd0;
    assign o_write_data = o_wr_en ? r_wdata : 32'd0;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_err_cause  = r_err_cause;
    assign o_load_data  = r_load_data;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: byte-level reference memory model,
// memory responder with programmable read latency, and a decoupled monitor.
module tb_lsu_mem_master;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req, i_is_store, i_rd_ack;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_store_data, i_read_data;
    logic        o_ready, o_done, o_err, o_stb, o_wr_en;
    logic [1:0]  o_err_cause;
    logic [31:0] o_load_data, o_addr, o_write_data;

    lsu_mem_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_store_data(i_store_data),
        .o_ready(o_ready), .o_done(o_done), .o_load_data(o_load_data),
        .o_err(o_err), .o_err_cause(o_err_cause),
        .o_stb(o_stb), .o_wr_en(o_wr_en), .o_addr(o_addr), .o_write_data(o_write_data),
        .i_rd_ack(i_rd_ack), .i_read_data(i_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t_done;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] load;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          rd_cyc;
        int          wr_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  ref_bytes [512];
    logic [31:0] dut_mem [128];
    logic [31:0] last_load = 32'd0;
    int          cur_delay = 0;
    int          rd_wait = 0;
    int          mon_rd = 0;
    int          mon_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks a read once it has waited cur_delay RD cycles.
    always @(negedge clk) begin
        if (o_stb && !o_wr_en) begin
            i_rd_ack    = (rd_wait >= cur_delay);
            i_read_data = i_rd_ack ? dut_mem[o_addr[8:2]] : $urandom;
            rd_wait++;
        end else begin
            i_rd_ack    = 1'b0;
            i_read_data = $urandom;
            rd_wait     = 0;
            if (o_wr_en) dut_mem[o_addr[8:2]] = o_write_data;
        end
    end

    // Monitor: bus-phase checks each cycle, response checks on o_done.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_rd = 0;
            mon_wr = 0;
            check("rst_ready", o_ready, 1);
            check("rst_done", o_done, 0);
            check("rst_err", {o_err, o_err_cause}, 0);
            check("rst_bus", {o_stb, o_wr_en}, 0);
            check("rst_addr", o_addr, 0);
            check("rst_wdata", o_write_data, 0);
            check("rst_load", o_load_data, 0);
        end else begin
            check("ready_vs_stb", o_ready, !o_stb);
            if (!o_stb) begin
                check("idle_wr_en", o_wr_en, 0);
                check("idle_addr", o_addr, 0);
                check("idle_wdata", o_write_data, 0);
            end else if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bus_unexpected: stb=1 addr=%h with nothing outstanding", o_addr);
            end else begin
                check("bus_addr", o_addr, sb_q[0].waddr);
                if (o_wr_en) begin
                    mon_wr++;
                    check("wr_data", o_write_data, sb_q[0].wdata);
                end else begin
                    mon_rd++;
                end
            end
            if (o_done) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: o_done=1 with nothing outstanding");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("latency", cyc, mon_e.t_done);
                    check("err", o_err, mon_e.err);
                    check("cause", o_err_cause, mon_e.cause);
                    check("load_data", o_load_data, mon_e.load);
                    check("rd_cycles", mon_rd, mon_e.rd_cyc);
                    check("wr_cycles", mon_wr, mon_e.wr_cyc);
                end
                mon_rd = 0;
                mon_wr = 0;
            end else begin
                check("err_wo_done", {o_err, o_err_cause}, 0);
                if (sb_q.size() > 0 && cyc > sb_q[0].t_done) begin
                    total++;
                    bad++;
                    $display("FAIL done_missing: due=%0d now=%0d", sb_q[0].t_done, cyc);
                    void'(sb_q.pop_front());
                    mon_rd = 0;
                    mon_wr = 0;
                end
            end
        end
    end

    // Reference model: byte-addressed memory, outcome decided from the ISA rules.
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] data, input int delay, input int t,
                                   output logic commit);
        exp_t        e;
        int          size;
        int          base;
        logic        legal;
        logic [31:0] v;
        logic [7:0]  nb [4];
        commit  = 1'b0;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal   = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        base    = int'(addr[8:2]) * 4;
        e.waddr = addr & ~32'h3;
        e.load  = last_load;
        e.err   = 1'b0;
        e.cause = 2'd0;
        e.wdata = 32'd0;
        e.rd_cyc = 0;
        e.wr_cyc = 0;
        for (int k = 0; k < 4; k++) nb[k] = ref_bytes[base + k];
        for (int k = 0; k < size && k < 4; k++) begin
            if (int'(addr[1:0]) + k < 4) nb[int'(addr[1:0]) + k] = data[8*k +: 8];
        end
        if (!legal) begin
            e.err = 1'b1; e.cause = 2'd2; e.t_done = t + 1;
        end else if (addr % size != 0) begin
            e.err = 1'b1; e.cause = 2'd1; e.t_done = t + 1;
        end else if (st && size == 4) begin
            e.t_done = t + 2; e.wr_cyc = 1; e.wdata = {nb[3], nb[2], nb[1], nb[0]}; commit = 1'b1;
        end else if (delay >= TIMEOUT) begin
            e.err = 1'b1; e.cause = 2'd3; e.t_done = t + 1 + TIMEOUT; e.rd_cyc = TIMEOUT;
        end else if (st) begin
            e.t_done = t + 3 + delay; e.rd_cyc = delay + 1; e.wr_cyc = 1;
            e.wdata = {nb[3], nb[2], nb[1], nb[0]}; commit = 1'b1;
        end else begin
            v = 32'd0;
            for (int k = 0; k < size; k++) v = v | (32'(ref_bytes[int'(addr[8:0]) + k]) << (8*k));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8*size));
            e.load = v; e.t_done = t + 2 + delay; e.rd_cyc = delay + 1;
        end
        return e;
    endfunction

    // abort: 0 none, 1 reset while in RD, 2 reset while in WR.
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input int delay, input int abort, input logic noise);
        exp_t e;
        logic commit;
        int   n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            total++;
            bad++;
            $display("FAIL ready_wait: o_ready stuck at 0");
            return;
        end
        e = model(st, f3, addr, data, delay, cyc, commit);
        sb_q.push_back(e);
        if (abort == 0) begin
            last_load = e.load;
            if (commit) begin
                for (int k = 0; k < 4 && k < (1 << f3[1:0]); k++) ref_bytes[int'(addr[8:0]) + k] = data[8*k +: 8];
            end
        end
        cur_delay    = delay;
        i_is_store   = st;
        i_funct3     = f3;
        i_addr       = addr;
        i_store_data = data;
        i_req        = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        if (abort != 0) begin
            if (abort == 2) begin
                @(posedge clk);
                #1;
            end
            check("pre_abort_wr_en", o_wr_en, (abort == 2));
            check("pre_abort_stb", o_stb, 1);
            rst_n = 1'b0;
            #1;
            check("abort_bus_drop", {o_stb, o_wr_en}, 0);
            check("abort_addr", o_addr, 0);
            sb_q.delete();
            last_load = 32'd0;
            @(negedge clk);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end else if (noise && !(e.err && e.cause != 2'd3)) begin
            i_is_store   = $urandom_range(0, 1);
            i_funct3     = 3'($urandom_range(0, 7));
            i_addr       = $urandom_range(0, 511);
            i_store_data = $urandom;
            i_req        = 1'b1;
            @(posedge clk);
            #1;
            i_req = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr, w;
        int          delay, n;
        i_req = 1'b0; i_is_store = 1'b0; i_funct3 = 3'd0; i_addr = 32'd0;
        i_store_data = 32'd0; i_rd_ack = 1'b0; i_read_data = 32'd0;
        for (int i = 0; i < 128; i++) begin
            w = (i == 64) ? 32'h8899AABB : $urandom;
            dut_mem[i] = w;
            for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 3'd0, 32'h101, 32'h0, 0, 0, 0);          // LB
        send(0, 3'd4, 32'h103, 32'h0, 0, 0, 0);          // LBU
        send(0, 3'd1, 32'h102, 32'h0, 0, 0, 0);          // LH
        send(0, 3'd2, 32'h100, 32'h0, 0, 0, 0);          // LW
        send(1, 3'd0, 32'h102, 32'h12345677, 0, 0, 0);   // SB
        send(1, 3'd1, 32'h100, 32'h0000CAFE, 0, 0, 0);   // SH
        send(0, 3'd2, 32'h100, 32'h0, 1, 0, 0);
        send(1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 0, 0);   // SW then immediate LW
        send(0, 3'd2, 32'h104, 32'h0, 0, 0, 0);
        send(1, 3'd1, 32'h101, 32'h0, 0, 0, 0);          // misaligned SH
        send(0, 3'd6, 32'h100, 32'h0, 0, 0, 0);          // illegal load
        send(1, 3'd2, 32'h102, 32'h0, 0, 0, 0);          // misaligned SW
        send(1, 3'd3, 32'h101, 32'h0, 0, 0, 0);          // illegal beats misaligned
        send(0, 3'd1, 32'h103, 32'h0, 0, 0, 0);          // misaligned LH
        send(0, 3'd5, 32'h102, 32'h0, 2, 0, 0);          // LHU
        send(0, 3'd2, 32'h100, 32'h0, 99, 0, 0);         // read timeout
        send(0, 3'd2, 32'h100, 32'h0, 4, 0, 0);          // ack on 5th RD cycle
        send(0, 3'd2, 32'h100, 32'h0, 15, 0, 0);         // ack on last cycle before timeout
        send(1, 3'd0, 32'h101, 32'h55, 99, 0, 0);        // SB timeout: no write
        send(1, 3'd0, 32'h102, 32'h11, 50, 1, 0);        // reset during RD
        send(1, 3'd0, 32'h102, 32'h22, 0, 2, 0);         // reset during WR
        send(0, 3'd2, 32'h100, 32'h0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                n  = $urandom_range(0, 4);
                f3 = (n < 3) ? 3'(n) : 3'(n + 1);
            end
            addr = $urandom_range(0, 511);
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            delay = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(st, f3, addr, $urandom, delay, 0, ($urandom_range(0, 3) == 0));
        end

        n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d responses never arrived", sb_q.size());
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            check($sformatf("mem[%0d]", i), dut_mem[i],
                  {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
